clk_period_meter: RTL

//  Measures the waveform produced by the integer clock divider: period and high time of
//  sig_in, counted in cycles of clk. Sits downstream of a divider output (or any slow

---
 rtl/clk_period_meter_pkg.sv | 17 +
 rtl/clk_period_meter_sync_2ff.sv | 27 ++
 rtl/clk_period_meter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for clock/waveform measurement blocks: FSM state
// encodings and default counter sizing.
package clk_period_meter_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_TIMEOUT = 1000;

   // WAIT_RISE/HIGH/LOW encodings are shared with future duty checkers;
   // ST_RUN is used only when high-time capture is compiled out.
   typedef enum logic [1:0] {
      ST_WAIT_RISE = 2'd0,
      ST_HIGH      = 2'd1,
      ST_LOW       = 2'd2,
      ST_RUN       = 2'd3
   } meas_state_t;

endpackage

// File: rtl/clk_period_meter_sync_2ff.sv
// Two-stage synchronizer for a single asynchronous bit; both stages reset
// to 0 so a held-high input shows up as a clean rising edge after reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // NOTE: registers use non-blocking assignment so both stages sample the
   // pre-edge values; blocking here would collapse the chain to one flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/clk_period_meter.sv
// Period / high-time meter for a slow periodic signal, counted in clk cycles.
// Define CLK_PERIOD_METER_DUTY_EN to enable high-time capture; otherwise high_time is 0.
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             meas_valid,
   output logic             timeout
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TO_VAL  = WIDTH'(TIMEOUT);

   logic             w_sig_s;
   logic             r_sig_d;
   logic             w_rise;
   logic             w_to_hit;
   logic [WIDTH-1:0] r_run_cnt;
   logic [WIDTH-1:0] r_period;
   logic             r_meas_valid;
   logic             r_timeout;
   meas_state_t      r_state;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (sig_in),
      .o_q   (w_sig_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig_d <= 1'b0;
      end else begin
         r_sig_d <= w_sig_s;
      end
   end

   assign w_rise   = w_sig_s & ~r_sig_d;
   assign w_to_hit = (r_run_cnt == TO_VAL);

   // Restarting at 1 on the rise makes run_cnt equal the full period at the next rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_cnt <= '0;
      end else if (w_rise) begin
         r_run_cnt <= CNT_ONE;
      end else if (r_run_cnt != CNT_MAX) begin
         r_run_cnt <= r_run_cnt + CNT_ONE;
      end
   end

`ifdef CLK_PERIOD_METER_DUTY_EN
   logic             w_fall;
   logic [WIDTH-1:0] r_hi_cap;
   logic [WIDTH-1:0] r_high_time;

   assign w_fall = ~w_sig_s & r_sig_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_WAIT_RISE;
         r_period     <= '0;
         r_high_time  <= '0;
         r_hi_cap     <= '0;
         r_meas_valid <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         if (w_rise) begin
            r_timeout <= 1'b0;
         end
         case (r_state)
            ST_WAIT_RISE: begin
               if (w_rise) begin
                  r_state <= ST_HIGH;
               end
            end
            // A rise while still in HIGH means the fall was missed; it closes the period as from LOW.
            ST_HIGH, ST_LOW: begin
               if (w_rise) begin
                  r_period     <= r_run_cnt;
                  r_high_time  <= r_hi_cap;
                  r_meas_valid <= 1'b1;
                  r_state      <= ST_HIGH;
               end else if (w_to_hit) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_WAIT_RISE;
               end else if ((r_state == ST_HIGH) && w_fall) begin
                  r_hi_cap <= r_run_cnt;
                  r_state  <= ST_LOW;
               end
            end
            default: r_state <= ST_WAIT_RISE;
         endcase
      end
   end

   assign high_time = r_high_time;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_WAIT_RISE;
         r_period     <= '0;
         r_meas_valid <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         if (w_rise) begin
            r_timeout <= 1'b0;
         end
         case (r_state)
            ST_WAIT_RISE: begin
               if (w_rise) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_rise) begin
                  r_period     <= r_run_cnt;
                  r_meas_valid <= 1'b1;
               end else if (w_to_hit) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_WAIT_RISE;
               end
            end
            default: r_state <= ST_WAIT_RISE;
         endcase
      end
   end

   assign high_time = '0;
`endif

   assign period     = r_period;
   assign meas_valid = r_meas_valid;
   assign timeout    = r_timeout;

endmodule
